// File: rtl/imm_pkg.sv
// Shared encodings for the 16->32-bit immediate sequencer.
package imm_pkg;

    localparam int unsigned IMM_W = 16;
    localparam int unsigned VAL_W = 32;

    // Instruction immediate classes as presented by decode
    localparam logic [1:0] IMM_SIGN  = 2'b00;
    localparam logic [1:0] IMM_ZLOW  = 2'b01;
    localparam logic [1:0] IMM_ZHIGH = 2'b10;
    localparam logic [1:0] IMM_LI32  = 2'b11;

    // Extension modes reported on ext_mode
    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZLOW  = 2'b01;
    localparam logic [1:0] MODE_ZHIGH = 2'b10;
    localparam logic [1:0] MODE_LI32  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_LOW = 2'b01,
        ST_HOLD     = 2'b10
    } state_t;

endpackage

// File: rtl/imm_ext.sv
// Combinational 3-mode 16->32-bit immediate extender.
module imm_ext #(
    parameter logic [1:0] MODE_SIGN  = imm_pkg::MODE_SIGN,
    parameter logic [1:0] MODE_ZLOW  = imm_pkg::MODE_ZLOW,
    parameter logic [1:0] MODE_ZHIGH = imm_pkg::MODE_ZHIGH
) (
    input  logic [1:0]                 i_mode,
    input  logic [imm_pkg::IMM_W-1:0]  i_imm16,
    output logic [imm_pkg::VAL_W-1:0]  o_imm32_c
);

    // Select extension; any unlisted mode falls back to sign extension
    always_comb begin
        o_imm32_c = {{16{i_imm16[15]}}, i_imm16};
        if (i_mode == MODE_ZLOW) begin
            o_imm32_c = {i_imm16, 16'h0000};
        end else if (i_mode == MODE_ZHIGH) begin
            o_imm32_c = {16'h0000, i_imm16};
        end else if (i_mode == MODE_SIGN) begin
            o_imm32_c = {{16{i_imm16[15]}}, i_imm16};
        end
    end

endmodule

// File: rtl/imm_sequencer.sv
// Immediate sequencer: per-class extension, two-beat LI32 assembly and a
// registered output slot with valid/ready handshakes on both sides.
module imm_sequencer #(
    parameter logic [1:0] MODE_SIGN  = imm_pkg::MODE_SIGN,
    parameter logic [1:0] MODE_ZLOW  = imm_pkg::MODE_ZLOW,
    parameter logic [1:0] MODE_ZHIGH = imm_pkg::MODE_ZHIGH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [1:0]                  imm_class,
    input  logic [imm_pkg::IMM_W-1:0]   imm16,
    output logic                        imm_valid,
    input  logic                        imm_ready,
    output logic [imm_pkg::VAL_W-1:0]   imm_value,
    output logic [1:0]                  ext_mode,
    output logic                        li32_pending
);
    import imm_pkg::*;

    state_t             r_state;
    state_t             w_next_state;
    logic [VAL_W-1:0]   r_partial;
    logic [VAL_W-1:0]   r_imm_value;
    logic [1:0]         r_ext_mode;

    logic               w_accept;
    logic [1:0]         w_beat_mode;
    logic [1:0]         w_ext_sel;
    logic [VAL_W-1:0]   w_ext_value;
    logic [VAL_W-1:0]   w_out_value;
    logic [1:0]         w_out_mode;
    logic               w_load_out;
    logic               w_load_part;
    logic               w_clr_part;

    // Flush always reads ready so decode can retire the dropped beat
    assign instr_ready  = flush || (r_state != ST_HOLD) || imm_ready;
    assign w_accept     = instr_valid && instr_ready && !flush;
    assign imm_valid    = (r_state == ST_HOLD);
    assign li32_pending = (r_state == ST_WAIT_LOW);
    assign imm_value    = r_imm_value;
    assign ext_mode     = r_ext_mode;

    // Map a first-beat class to its extension mode (LI32 high half is zero-low)
    always_comb begin
        w_beat_mode = MODE_ZLOW;
        case (imm_class)
            IMM_SIGN:  w_beat_mode = MODE_SIGN;
            IMM_ZLOW:  w_beat_mode = MODE_ZLOW;
            IMM_ZHIGH: w_beat_mode = MODE_ZHIGH;
            default:   w_beat_mode = MODE_ZLOW;
        endcase
    end

    imm_ext #(
        .MODE_SIGN  (MODE_SIGN),
        .MODE_ZLOW  (MODE_ZLOW),
        .MODE_ZHIGH (MODE_ZHIGH)
    ) u_ext (
        .i_mode    (w_ext_sel),
        .i_imm16   (imm16),
        .o_imm32_c (w_ext_value)
    );

    // Next-state and datapath load controls
    always_comb begin
        w_next_state = r_state;
        w_ext_sel    = w_beat_mode;
        w_out_value  = w_ext_value;
        w_out_mode   = w_beat_mode;
        w_load_out   = 1'b0;
        w_load_part  = 1'b0;
        w_clr_part   = 1'b0;
        if (flush) begin
            w_next_state = ST_IDLE;
            w_clr_part   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_accept) begin
                        if (imm_class == IMM_LI32) begin
                            w_load_part  = 1'b1;
                            w_next_state = ST_WAIT_LOW;
                        end else begin
                            w_load_out   = 1'b1;
                            w_next_state = ST_HOLD;
                        end
                    end else if ((r_state == ST_HOLD) && imm_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    w_ext_sel   = MODE_ZHIGH;
                    w_out_value = r_partial | w_ext_value;
                    w_out_mode  = MODE_LI32;
                    if (w_accept) begin
                        w_load_out   = 1'b1;
                        w_next_state = ST_HOLD;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Partial literal and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_partial   <= '0;
            r_imm_value <= '0;
            r_ext_mode  <= MODE_SIGN;
        end else begin
            if (w_clr_part) begin
                r_partial <= '0;
            end else if (w_load_part) begin
                r_partial <= w_ext_value;
            end
            if (w_load_out) begin
                r_imm_value <= w_out_value;
                r_ext_mode  <= w_out_mode;
            end
        end
    end

endmodule

// File: tb/tb_imm_sequencer.sv
// Randomized scoreboard bench for imm_sequencer with a transaction-level model.
module tb_imm_sequencer;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  imm_class;
    logic [15:0] imm16;
    logic        imm_valid;
    logic        imm_ready;
    logic [31:0] imm_value;
    logic [1:0]  ext_mode;
    logic        li32_pending;

    imm_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .imm_class    (imm_class),
        .imm16        (imm16),
        .imm_valid    (imm_valid),
        .imm_ready    (imm_ready),
        .imm_value    (imm_value),
        .ext_mode     (ext_mode),
        .li32_pending (li32_pending)
    );

    typedef struct {
        logic [31:0] value;
        logic [1:0]  mode;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_init = 0;
    bit          m_hold = 0;
    bit          m_pend = 0;
    bit          m_just_reset = 0;
    logic [15:0] m_hi = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference extension computed arithmetically from the class rules
    function automatic logic [31:0] ref_ext(input logic [1:0] cls, input logic [15:0] v);
        logic [31:0] r;
        case (cls)
            2'd0:    r = (v >= 16'h8000) ? (32'(v) + 32'hFFFF0000) : 32'(v);
            2'd1:    r = 32'(v) * 32'd65536;
            default: r = 32'(v);
        endcase
        return r;
    endfunction

    // One cycle: drive inputs, check handshake outputs mid-cycle, advance model at the edge
    task automatic step(input logic v, input logic [1:0] cls, input logic [15:0] d,
                        input logic rdy, input logic fl, input logic rst);
        bit   acc;
        exp_t e;
        instr_valid = v;
        imm_class   = cls;
        imm16       = d;
        imm_ready   = rdy;
        flush       = fl;
        reset       = rst;
        @(negedge clock);
        if (m_init) begin
            checks++;
            if (instr_ready !== (fl || !m_hold || rdy)) begin
                errors++;
                $display("FAIL instr_ready: got %b expected %b at %0t", instr_ready, (fl || !m_hold || rdy), $time);
            end
            checks++;
            if (li32_pending !== m_pend) begin
                errors++;
                $display("FAIL li32_pending: got %b expected %b at %0t", li32_pending, m_pend, $time);
            end
        end
        @(posedge clock);
        m_just_reset = 0;
        if (rst) begin
            m_init = 1; m_hold = 0; m_pend = 0; m_just_reset = 1;
            q.delete();
        end else if (fl) begin
            m_hold = 0; m_pend = 0;
            q.delete();
        end else begin
            acc = v && (!m_hold || rdy);
            if (m_hold && rdy) m_hold = 0;
            if (acc) begin
                if (m_pend) begin
                    e.value = 32'(m_hi) * 32'd65536 + 32'(d);
                    e.mode  = 2'b11;
                    q.push_back(e);
                    m_pend = 0;
                    m_hold = 1;
                end else if (cls == 2'b11) begin
                    m_hi   = d;
                    m_pend = 1;
                end else begin
                    e.value = ref_ext(cls, d);
                    e.mode  = cls;
                    q.push_back(e);
                    m_hold = 1;
                end
            end
        end
        #1;
    endtask

    // Monitor: compare presented immediates against the scoreboard, pop on consumption
    always @(negedge clock) begin
        if (m_init) begin
            checks++;
            if (imm_valid !== m_hold) begin
                errors++;
                $display("FAIL imm_valid: got %b expected %b at %0t", imm_valid, m_hold, $time);
            end
            if (m_just_reset) begin
                checks++;
                if (imm_value !== 32'h0 || ext_mode !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_state: got value %h mode %b expected 00000000 00 at %0t", imm_value, ext_mode, $time);
                end
            end
            if (imm_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_imm: got %h with empty scoreboard at %0t", imm_value, $time);
                end else begin
                    if (imm_value !== q[0].value || ext_mode !== q[0].mode) begin
                        errors++;
                        $display("FAIL imm_out: got %h mode %b expected %h mode %b at %0t",
                                 imm_value, ext_mode, q[0].value, q[0].mode, $time);
                    end
                    if (imm_ready === 1'b1) void'(q.pop_front());
                end
            end
        end
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        instr_valid = 0; imm_class = 0; imm16 = 0; imm_ready = 1; flush = 0; reset = 1;
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);

        // Sign extension, negative and positive
        step(1, 0, 16'h8001, 1, 0, 0);
        step(1, 0, 16'h7FFF, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Zero-low then zero-high back to back
        step(1, 1, 16'h1234, 1, 0, 0);
        step(1, 2, 16'h1234, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // LI32 with a two-cycle gap; class on the second beat is ignored
        step(1, 3, 16'hDEAD, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 16'hBEEF, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Backpressure: offered beats must not be taken while held
        step(1, 0, 16'h8001, 1, 0, 0);
        step(1, 2, 16'h1111, 0, 0, 0);
        step(1, 2, 16'h2222, 0, 0, 0);
        step(1, 2, 16'h3333, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Flush during WAIT_LOW with a beat offered, then a fresh sign beat
        step(1, 3, 16'hDEAD, 1, 0, 0);
        step(1, 0, 16'h4444, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 16'h0005, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset in HOLD with backpressure, then reset together with flush
        step(1, 0, 16'h8001, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 16'hABCD, 1, 0, 0);
        step(1, 0, 16'h5555, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 16'($urandom),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 59) == 0),
                 logic'($urandom_range(0, 199) == 0));
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
